// File: rtl/clb_cfg_pkg.sv
// Shared constants, state encoding and CFG field map for the CLB config loader.
// Build option: CLB_CFG_CRC_EN selects an 8-bit CRC check field instead of one parity bit.
package clb_cfg_pkg;

  localparam int unsigned CFG_W  = 37;
  localparam int unsigned ADDR_W = 8;
  localparam logic [7:0]  SYNC   = 8'hB5;

  localparam logic [7:0]  CRC_POLY = 8'h07;
  localparam logic [7:0]  CRC_INIT = 8'h00;

`ifdef CLB_CFG_CRC_EN
  localparam int unsigned CHK_W = 8;
`else
  localparam int unsigned CHK_W = 1;
`endif

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_ADDR,
    ST_DATA,
    ST_CHK,
    ST_COMMIT,
    ST_ERR
  } state_t;

  localparam int unsigned OFS_MUX2SEL    = 35;
  localparam int unsigned OFS_MUX3SEL    = 33;
  localparam int unsigned OFS_MUX4SEL    = 31;
  localparam int unsigned OFS_MUX5SEL    = 29;
  localparam int unsigned OFS_MUX6SEL    = 27;
  localparam int unsigned OFS_LUT        = 11;
  localparam int unsigned OFS_COMBOPTION = 9;
  localparam int unsigned OFS_O2M        = 3;
  localparam int unsigned OFS_DQMUX      = 1;
  localparam int unsigned OFS_FLOPLATCH  = 0;

  typedef struct packed {
    logic [1:0]  mux2sel;
    logic [1:0]  mux3sel;
    logic [1:0]  mux4sel;
    logic [1:0]  mux5sel;
    logic [1:0]  mux6sel;
    logic [15:0] lut_mem;
    logic [1:0]  comboption;
    logic        o2m1_0;
    logic        o2m2_0;
    logic        o2m3_0;
    logic        o2m1_1;
    logic        o2m2_1;
    logic        o2m3_1;
    logic        dqmux1;
    logic        dqmux2;
    logic        floporlatch;
  } cfg_word_t;

endpackage

// File: rtl/clb_cfg_chk.sv
// Serial check accumulator over the ADDR+DATA bits of a frame.
// CLB_CFG_CRC_EN: CRC-8 (poly 0x07, MSB first); otherwise running even parity.
module clb_cfg_chk
  import clb_cfg_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_bit_in,
  input  logic             i_bit_en,
  output logic [CHK_W-1:0] o_result
);

  logic [CHK_W-1:0] r_acc;
  logic [CHK_W-1:0] w_acc_nxt;

`ifdef CLB_CFG_CRC_EN
  localparam logic [CHK_W-1:0] CHK_INIT = CRC_INIT;

  always_comb begin
    w_acc_nxt = {r_acc[CHK_W-2:0], 1'b0};
    if (r_acc[CHK_W-1] ^ i_bit_in) begin
      w_acc_nxt = w_acc_nxt ^ CRC_POLY;
    end
  end
`else
  localparam logic [CHK_W-1:0] CHK_INIT = '0;

  always_comb begin
    w_acc_nxt = r_acc ^ i_bit_in;
  end
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_acc <= CHK_INIT;
    end else if (i_clear) begin
      r_acc <= CHK_INIT;
    end else if (i_bit_en) begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_result = r_acc;

endmodule

// File: rtl/clb_cfg_loader.sv
// Serial config bitstream deserialiser: SYNC, address, 37-bit CLB word, check field; commits good frames.
// Build option: CLB_CFG_CRC_EN (CRC-8 check field; default is one even-parity bit).
module clb_cfg_loader
  import clb_cfg_pkg::*;
#(
  parameter int unsigned NFRAMES  = 16,
  parameter logic [7:0]  SYNC_PAT = SYNC
) (
  input  logic              K,
  input  logic              RST_N,
  input  logic              DIN,
  input  logic              DVALID,
  output logic              DRDY,
  output logic [CFG_W-1:0]  CFG,
  output logic [ADDR_W-1:0] CFG_ADDR,
  output logic              CFG_WE,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR
);

  localparam int unsigned BCNT_W = $clog2(CFG_W);
  localparam int unsigned FC_W   = $clog2(NFRAMES + 1);

  state_t              r_state;
  logic [7:0]          r_shreg;
  logic [ADDR_W-1:0]   r_addr_sh;
  logic [CFG_W-1:0]    r_data_sh;
  logic [CHK_W-1:0]    r_chk_sh;
  logic [BCNT_W-1:0]   r_bitcnt;
  logic [FC_W-1:0]     r_frames;
  cfg_word_t           r_cfg;
  logic [ADDR_W-1:0]   r_cfg_addr;
  logic                r_we;
  logic                r_done;
  logic                r_err;

  logic                w_drdy;
  logic                w_accept;
  logic [7:0]          w_shreg_nxt;
  logic [CHK_W-1:0]    w_chk_nxt;
  logic [CHK_W-1:0]    w_chk_res;
  logic                w_chk_clear;
  logic                w_chk_en;

  assign w_drdy      = (r_state != ST_COMMIT) && (r_state != ST_ERR);
  assign w_accept    = DVALID && w_drdy;
  assign w_shreg_nxt = {r_shreg[6:0], DIN};
  // Truncating cast keeps the low CHK_W bits, so this works for both 1- and 8-bit check fields.
  assign w_chk_nxt   = CHK_W'({r_chk_sh, DIN});
  assign w_chk_clear = (r_state == ST_HUNT);
  assign w_chk_en    = w_accept && ((r_state == ST_ADDR) || (r_state == ST_DATA));

  clb_cfg_chk u_chk (
    .i_clk    (K),
    .i_rst_n  (RST_N),
    .i_clear  (w_chk_clear),
    .i_bit_in (DIN),
    .i_bit_en (w_chk_en),
    .o_result (w_chk_res)
  );

  always_ff @(posedge K or negedge RST_N) begin
    if (!RST_N) begin
      r_state    <= ST_HUNT;
      r_shreg    <= '0;
      r_addr_sh  <= '0;
      r_data_sh  <= '0;
      r_chk_sh   <= '0;
      r_bitcnt   <= '0;
      r_frames   <= '0;
      r_cfg      <= '0;
      r_cfg_addr <= '0;
      r_we       <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_we <= 1'b0;
      case (r_state)
        ST_HUNT: begin
          if (w_accept) begin
            // Clearing on lock means the next hunt needs all 8 fresh bits to match.
            if (w_shreg_nxt == SYNC_PAT) begin
              r_shreg  <= '0;
              r_bitcnt <= '0;
              r_state  <= ST_ADDR;
            end else begin
              r_shreg <= w_shreg_nxt;
            end
          end
        end
        ST_ADDR: begin
          if (w_accept) begin
            r_addr_sh <= {r_addr_sh[ADDR_W-2:0], DIN};
            if (r_bitcnt == BCNT_W'(ADDR_W - 1)) begin
              r_bitcnt <= '0;
              r_state  <= ST_DATA;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_DATA: begin
          if (w_accept) begin
            r_data_sh <= {r_data_sh[CFG_W-2:0], DIN};
            if (r_bitcnt == BCNT_W'(CFG_W - 1)) begin
              r_bitcnt <= '0;
              r_state  <= ST_CHK;
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_CHK: begin
          if (w_accept) begin
            r_chk_sh <= w_chk_nxt;
            if (r_bitcnt == BCNT_W'(CHK_W - 1)) begin
              r_bitcnt <= '0;
              if (w_chk_nxt == w_chk_res) begin
                r_state    <= ST_COMMIT;
                r_cfg      <= cfg_word_t'(r_data_sh);
                r_cfg_addr <= r_addr_sh;
                r_we       <= 1'b1;
                if (r_frames != FC_W'(NFRAMES)) begin
                  r_frames <= r_frames + 1'b1;
                end
                if (r_frames == FC_W'(NFRAMES - 1)) begin
                  r_done <= 1'b1;
                end
              end else begin
                r_state <= ST_ERR;
                r_err   <= 1'b1;
              end
            end else begin
              r_bitcnt <= r_bitcnt + 1'b1;
            end
          end
        end
        ST_COMMIT: begin
          r_state <= ST_HUNT;
        end
        ST_ERR: begin
          r_state <= ST_ERR;
        end
        default: begin
          r_state <= ST_HUNT;
        end
      endcase
    end
  end

  assign DRDY     = w_drdy;
  assign BUSY     = (r_state != ST_HUNT);
  assign CFG      = r_cfg;
  assign CFG_ADDR = r_cfg_addr;
  assign CFG_WE   = r_we;
  assign DONE     = r_done;
  assign ERR      = r_err;

endmodule

// File: tb/tb_clb_cfg_loader.sv
// Directed self-checking bench for clb_cfg_loader (follows CLB_CFG_CRC_EN if defined).
module tb_clb_cfg_loader;

`ifdef CLB_CFG_CRC_EN
  localparam int CHKW = 8;
`else
  localparam int CHKW = 1;
`endif

  logic        K = 1'b0;
  logic        RST_N = 1'b0;
  logic        DIN = 1'b0;
  logic        DVALID = 1'b0;
  logic        DRDY;
  logic [36:0] CFG;
  logic [7:0]  CFG_ADDR;
  logic        CFG_WE;
  logic        BUSY;
  logic        DONE;
  logic        ERR;

  int n_assert = 0;
  int n_fail   = 0;
  int we_count = 0;

  clb_cfg_loader #(.NFRAMES(16), .SYNC_PAT(8'hB5)) dut (
    .K        (K),
    .RST_N    (RST_N),
    .DIN      (DIN),
    .DVALID   (DVALID),
    .DRDY     (DRDY),
    .CFG      (CFG),
    .CFG_ADDR (CFG_ADDR),
    .CFG_WE   (CFG_WE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  always #5 K = ~K;

  // Counts cycles with CFG_WE high, so a stretched strobe shows up as extra pulses.
  always @(negedge K) if (CFG_WE === 1'b1) we_count++;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] calc_chk(input logic [7:0] a, input logic [36:0] d);
    logic [44:0] bits;
    logic [7:0]  crc;
    bits = {a, d};
`ifdef CLB_CFG_CRC_EN
    crc = 8'h00;
    for (int i = 44; i >= 0; i--) begin
      if (crc[7] ^ bits[i]) crc = {crc[6:0], 1'b0} ^ 8'h07;
      else                  crc = {crc[6:0], 1'b0};
    end
`else
    crc = {7'b0, ^bits};
`endif
    return crc;
  endfunction

  task automatic do_reset();
    @(negedge K);
    RST_N = 1'b0;
    DVALID = 1'b0;
    @(negedge K);
    @(negedge K);
    RST_N = 1'b1;
  endtask

  task automatic send_bit(input logic b, input bit gap);
    int n;
    if (gap) begin
      @(negedge K);
      DVALID = 1'b0;
      @(posedge K);
    end
    @(negedge K);
    n = 0;
    while (DRDY !== 1'b1 && n < 50) begin
      @(negedge K);
      n++;
    end
    if (DRDY !== 1'b1) check("drdy_wait", {63'b0, DRDY}, 64'd1);
    DIN = b;
    DVALID = 1'b1;
    @(posedge K);
    #1;
    DVALID = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], gap);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [36:0] d, input bit gap,
                            input int flip, input bit with_sync);
    logic [7:0] c;
    c = calc_chk(a, d);
    if (with_sync) send_byte(8'hB5, gap);
    send_byte(a, gap);
    for (int i = 36; i >= 0; i--) send_bit(d[i] ^ (i == flip), gap);
    for (int i = CHKW - 1; i >= 0; i--) send_bit(c[i], gap);
  endtask

  initial begin
    int         we0;
    logic [36:0] d;

    // Reset state
    do_reset();
    #1;
    check("rst_cfg",   {27'b0, CFG}, 64'd0);
    check("rst_addr",  {56'b0, CFG_ADDR}, 64'd0);
    check("rst_we",    {63'b0, CFG_WE}, 64'd0);
    check("rst_done",  {63'b0, DONE}, 64'd0);
    check("rst_err",   {63'b0, ERR}, 64'd0);
    check("rst_busy",  {63'b0, BUSY}, 64'd0);
    check("rst_drdy",  {63'b0, DRDY}, 64'd1);

    // 1: single good frame
    we0 = we_count;
    send_frame(8'h03, 37'h15_0008_B038, 1'b0, -1, 1'b1);
    check("t1_we",   {63'b0, CFG_WE}, 64'd1);
    check("t1_addr", {56'b0, CFG_ADDR}, 64'h03);
    check("t1_cfg",  {27'b0, CFG}, 64'h15_0008_B038);
    check("t1_drdy_commit", {63'b0, DRDY}, 64'd0);
    repeat (3) @(posedge K);
    #1;
    check("t1_we_once", 64'(we_count - we0), 64'd1);
    check("t1_err",  {63'b0, ERR}, 64'd0);
    check("t1_busy_idle", {63'b0, BUSY}, 64'd0);

    // 2: same frame, DVALID low every other cycle
    do_reset();
    we0 = we_count;
    send_frame(8'h03, 37'h15_0008_B038, 1'b1, -1, 1'b1);
    check("t2_we_lat", {63'b0, CFG_WE}, 64'd1);
    check("t2_addr", {56'b0, CFG_ADDR}, 64'h03);
    check("t2_cfg",  {27'b0, CFG}, 64'h15_0008_B038);
    repeat (3) @(posedge K);
    #1;
    check("t2_we_once", 64'(we_count - we0), 64'd1);

    // 3: noise then sync; the extra 0 keeps the 5A tail from forming B5 with the sync's leading 1
    do_reset();
    we0 = we_count;
    send_byte(8'hFF, 1'b0);
    check("t3_nolock_ff", {63'b0, BUSY}, 64'd0);
    send_byte(8'h5A, 1'b0);
    check("t3_nolock_5a", {63'b0, BUSY}, 64'd0);
    send_bit(1'b0, 1'b0);
    d = 37'h0A_5A5A_C3C3;
    begin
      logic [7:0] s;
      s = 8'hB5;
      for (int i = 7; i >= 1; i--) send_bit(s[i], 1'b0);
      check("t3_nolock_7", {63'b0, BUSY}, 64'd0);
      send_bit(s[0], 1'b0);
      check("t3_lock", {63'b0, BUSY}, 64'd1);
    end
    send_frame(8'h7E, d, 1'b0, -1, 1'b0);
    check("t3_we",   {63'b0, CFG_WE}, 64'd1);
    check("t3_addr", {56'b0, CFG_ADDR}, 64'h7E);
    check("t3_cfg",  {27'b0, CFG}, {27'b0, d});
    repeat (2) @(posedge K);
    #1;
    check("t3_we_once", 64'(we_count - we0), 64'd1);

    // 4: flipped data bit -> sticky error
    do_reset();
    we0 = we_count;
    send_frame(8'h21, 37'h15_0008_B038, 1'b0, 17, 1'b1);
    check("t4_err",  {63'b0, ERR}, 64'd1);
    check("t4_we",   {63'b0, CFG_WE}, 64'd0);
    check("t4_drdy", {63'b0, DRDY}, 64'd0);
    repeat (5) @(posedge K);
    #1;
    check("t4_err_hold", {63'b0, ERR}, 64'd1);
    check("t4_no_we", 64'(we_count - we0), 64'd0);
    check("t4_cfg_kept", {27'b0, CFG}, 64'd0);
    @(negedge K);
    RST_N = 1'b0;
    #1;
    check("t4_rst_err",  {63'b0, ERR}, 64'd0);
    check("t4_rst_drdy", {63'b0, DRDY}, 64'd1);
    @(negedge K);
    RST_N = 1'b1;

    // 5: full load of 16 frames, then one more after DONE
    do_reset();
    we0 = we_count;
    for (int f = 0; f < 16; f++) begin
      d = {5'(f), 32'hC0DE_0000 | 32'(f * 32'h111)};
      send_frame(8'(f), d, 1'b0, -1, 1'b1);
      check("t5_addr", {56'b0, CFG_ADDR}, 64'(f));
      check("t5_cfg",  {27'b0, CFG}, {27'b0, d});
      check("t5_done", {63'b0, DONE}, (f == 15) ? 64'd1 : 64'd0);
    end
    repeat (2) @(posedge K);
    #1;
    check("t5_we_count", 64'(we_count - we0), 64'd16);
    d = 37'h1F_FFFF_0001;
    send_frame(8'hAA, d, 1'b0, -1, 1'b1);
    check("t5_post_we",   {63'b0, CFG_WE}, 64'd1);
    check("t5_post_cfg",  {27'b0, CFG}, {27'b0, d});
    check("t5_post_done", {63'b0, DONE}, 64'd1);

    // 6: reset during DATA bit 20
    repeat (2) @(posedge K);
    #1;
    we0 = we_count;
    send_byte(8'hB5, 1'b0);
    send_byte(8'h44, 1'b0);
    d = 37'h12_3456_789A;
    for (int i = 36; i >= 16; i--) send_bit(d[i], 1'b0);
    RST_N = 1'b0;
    #1;
    check("t6_cfg",  {27'b0, CFG}, 64'd0);
    check("t6_addr", {56'b0, CFG_ADDR}, 64'd0);
    check("t6_done", {63'b0, DONE}, 64'd0);
    check("t6_busy", {63'b0, BUSY}, 64'd0);
    check("t6_drdy", {63'b0, DRDY}, 64'd1);
    @(negedge K);
    @(negedge K);
    RST_N = 1'b1;
    check("t6_no_we", 64'(we_count - we0), 64'd0);
    send_frame(8'h44, d, 1'b0, -1, 1'b1);
    check("t6_we",   {63'b0, CFG_WE}, 64'd1);
    check("t6_addr2", {56'b0, CFG_ADDR}, 64'h44);
    check("t6_cfg2", {27'b0, CFG}, {27'b0, d});
    check("t6_done2", {63'b0, DONE}, 64'd0);
    repeat (2) @(posedge K);
    #1;
    check("t6_we_once", 64'(we_count - we0), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
